// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: per-stage hold vector, divide sequencing, exception flush.
// Latency: pause is combinational; flush/new_pc/div_done/div_abort are registered (1 cycle after request).
// Backpressure: none accepted; it generates the hold vector that stalls the upstream stages.
module pipeline_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause_req_if,
    input  logic        pause_req_id,
    input  logic        pause_req_ex,
    input  logic        pause_req_mem,
    input  logic        div_start,
    input  logic        excp_req,
    input  logic [31:0] excp_pc,
    output logic [5:0]  pause,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        div_done,
    output logic        div_abort,
    output logic [31:0] stall_cycles
);

    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_BUSY = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] div_cnt_nxt;
    logic             flush_nxt;
    logic             done_nxt;
    logic             abort_nxt;

    always_comb begin
        state_nxt   = state;
        div_cnt_nxt = div_cnt;
        flush_nxt   = 1'b0;
        done_nxt    = 1'b0;
        abort_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (excp_req) begin
                    state_nxt = FLUSH;
                    flush_nxt = 1'b1;
                end else if (div_start) begin
                    state_nxt   = DIV_BUSY;
                    div_cnt_nxt = '0;
                end
            end
            DIV_BUSY: begin
                // An exception cancels the divide even on its final cycle.
                if (excp_req) begin
                    state_nxt   = FLUSH;
                    flush_nxt   = 1'b1;
                    abort_nxt   = 1'b1;
                    div_cnt_nxt = '0;
                end else if (div_cnt == CNT_LAST) begin
                    state_nxt   = IDLE;
                    done_nxt    = 1'b1;
                    div_cnt_nxt = '0;
                end else begin
                    div_cnt_nxt = div_cnt + 1'b1;
                end
            end
            FLUSH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt   = IDLE;
                div_cnt_nxt = '0;
            end
        endcase
    end

    // State terms are masked under reset so only live requests show while held.
    always_comb begin
        pause = 6'b000000;
        if ((state == FLUSH) && !rst) begin
            pause = 6'b000000;
        end else if (pause_req_mem) begin
            pause = 6'b011111;
        end else if (pause_req_ex || ((state == DIV_BUSY) && !rst)) begin
            pause = 6'b001111;
        end else if (pause_req_id) begin
            pause = 6'b000111;
        end else if (pause_req_if) begin
            pause = 6'b000011;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            div_cnt      <= '0;
            flush        <= 1'b0;
            new_pc       <= 32'h0;
            div_done     <= 1'b0;
            div_abort    <= 1'b0;
            stall_cycles <= 32'h0;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_cnt_nxt;
            flush     <= flush_nxt;
            div_done  <= done_nxt;
            div_abort <= abort_nxt;
            if (flush_nxt) begin
                new_pc <= excp_pc;
            end
            if ((pause != 6'b000000) && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter DIV_CYCLES, default 32, number of cycles a divide occupies the EX stage (range 2..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pause_req_if  input  1  fetch stage stall request.
REQ-005 pause_req_id  input  1  decode stage stall request (load-use hazard).
REQ-006 pause_req_ex  input  1  execute stage stall request.
REQ-007 pause_req_mem  input  1  memory stage stall request.
REQ-008 div_start  input  1  one-cycle pulse from EX: divide issued.
REQ-009 excp_req  input  1  exception or ertn commit request from MEM.
REQ-010 excp_pc  input  32  redirect target accompanying excp_req.
REQ-011 pause  output  6  per-stage hold vector; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
REQ-012 flush  output  1  registered; clears all pipeline registers for one cycle.
REQ-013 new_pc  output  32  registered redirect target, valid while flush=1.
REQ-014 div_done  output  1  registered one-cycle pulse: divide result valid in EX.
REQ-015 div_abort  output  1  registered one-cycle pulse: in-flight divide cancelled.
REQ-016 stall_cycles  output  32  performance counter of cycles with pause!=0.

Function
REQ-017 FSM states SHALL be IDLE, DIV_BUSY, FLUSH; state, counter and all registered outputs update only on rising clk.
REQ-018 IDLE: excp_req=1 -> FLUSH; else div_start=1 -> DIV_BUSY with div_cnt=0; else stay.
REQ-019 DIV_BUSY: div_cnt SHALL increment by 1 per cycle; at div_cnt=DIV_CYCLES-1 -> IDLE with div_done=1 in the next cycle.
REQ-020 DIV_BUSY with excp_req=1 SHALL take priority over completion: -> FLUSH, div_abort=1 next cycle, div_done stays 0.
REQ-021 FLUSH SHALL last exactly one cycle: flush=1, new_pc=excp_pc captured at request; then -> IDLE unconditionally.
REQ-022 excp_req during FLUSH SHALL be ignored; div_start during FLUSH or DIV_BUSY SHALL be ignored.
REQ-023 pause SHALL be combinational from state and requests, priority order: FLUSH -> 6'b000000; pause_req_mem -> 6'b011111; pause_req_ex or DIV_BUSY -> 6'b001111; pause_req_id -> 6'b000111; pause_req_if -> 6'b000011; else 6'b000000.
REQ-024 pause SHALL always be a contiguous run of ones from bit0 (stage i held implies all earlier stages held), so a stage with pause[i]=1, pause[i+1]=0 inserts a bubble.
REQ-025 In the final DIV_BUSY cycle (div_cnt=DIV_CYCLES-1) pause SHALL still reflect DIV_BUSY; release occurs the cycle div_done=1.
REQ-026 div_done, div_abort SHALL be 0 in every cycle not specified above; never both 1.
REQ-027 new_pc SHALL hold its last value when flush=0.
REQ-028 stall_cycles SHALL increment by 1 each cycle pause!=0 and saturate at 32'hFFFFFFFF (no wrap).
REQ-029 div_cnt width SHALL be $clog2(DIV_CYCLES); no overflow path exists.

Reset
REQ-030 rst=1 at a clock edge SHALL force state=IDLE, div_cnt=0, flush=0, new_pc=0, div_done=0, div_abort=0, stall_cycles=0, regardless of state, including mid-divide and mid-flush.
REQ-031 rst SHALL dominate excp_req and div_start in the same cycle; no pulse output follows reset release.
REQ-032 pause with rst held SHALL equal 6'b000000 unless a request input is 1.

Verification
REQ-033 Reset, then div_start pulse in IDLE, DIV_CYCLES=32 -> pause=6'b001111 for 32 cycles, div_done=1 on the 33rd cycle with pause=0, stall_cycles=32.
REQ-034 excp_req=1, excp_pc=32'h1C00_0100 at cycle 10 of a divide -> next cycle flush=1, new_pc=32'h1C00_0100, div_abort=1, pause=0; following cycle IDLE, flush=0, no div_done.
REQ-035 pause_req_id=1 and pause_req_mem=1 simultaneously -> pause=6'b011111; drop mem -> 6'b000111; drop id -> 6'b000000.
REQ-036 excp_req and div_start asserted together in IDLE -> FLUSH taken, divide never started, no div_done/div_abort.
REQ-037 rst pulsed at div_cnt=5 -> next cycle IDLE, pause=0, outputs zero; new div_start runs full 32 cycles.
REQ-038 Force stall_cycles near saturation (32'hFFFFFFFE) via long pause_req_if -> reaches 32'hFFFFFFFF and holds.
